// File: rtl/elastic_buffer_pkg.sv
// Shared helpers for the elastic buffer and its pointer counters.
package elastic_buffer_pkg;

  // Pointer width for an N-entry ring; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modn_counter.sv
// Wrapping modulo-N counter with enable, synchronous clear and async active-low reset.
module modn_counter
  import elastic_buffer_pkg::*;
#(
  parameter int unsigned MODULUS = 2,
  localparam int unsigned W = ptr_width(MODULUS)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == W'(MODULUS - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer; cuts ready timing, optional fall-through
// bypass when empty, synchronous flush and occupancy output.
module elastic_buffer
  import elastic_buffer_pkg::*;
#(
  parameter type         DATA_T       = logic,
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter bit          SKIP         = 1'b0,
  localparam int unsigned CntW        = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  DATA_T           data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output DATA_T           data_o,
  output logic [CntW-1:0] count_o
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("elastic_buffer: DEPTH must be >= 1");
  end

  if (SKIP) begin : g_skip
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign count_o = '0;
  end else begin : g_buf
    localparam int unsigned PtrW = ptr_width(DEPTH);

    DATA_T            mem_q [DEPTH];
    logic [PtrW-1:0]  head, tail;
    logic [CntW-1:0]  count_q, count_d;
    logic             empty, full, bypass_mode, bypass, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));

    // Bypass only while empty so ordering against stored items is preserved.
    assign bypass_mode = FALL_THROUGH && empty;
    assign bypass      = bypass_mode && valid_i && ready_i && !flush_i;

    assign ready_o = !full && !flush_i;
    assign valid_o = bypass_mode ? (valid_i && !flush_i) : (!empty && !flush_i);
    assign data_o  = bypass_mode ? data_i : mem_q[head];

    assign push = valid_i && ready_o && !bypass;
    assign pop  = valid_o && ready_i && !bypass;

    always_comb begin
      count_d = count_q;
      if (flush_i) begin
        count_d = '0;
      end else if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem_q[i] <= '0;
        end
      end else if (push) begin
        mem_q[tail] <= data_i;
      end
    end

    modn_counter #(
      .MODULUS(DEPTH)
    ) u_head (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .clr_i  (flush_i),
      .en_i   (pop),
      .cnt_o  (head)
    );

    modn_counter #(
      .MODULUS(DEPTH)
    ) u_tail (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .clr_i  (flush_i),
      .en_i   (push),
      .cnt_o  (tail)
    );

    assign count_o = count_q;

    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      count_q <= CntW'(DEPTH));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(push && full));
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(pop && empty));
  end

endmodule
